// File: rtl/syscall_disp_queue.sv
// syscall_disp_queue: captures syscall print values into a display FIFO and latches the exit halt flag.
module syscall_disp_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter logic [DATA_W-1:0] EXIT_CODE = 32'h0000000a,
  parameter int CNT_W = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              syscall,
  input  logic              stall,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  input  logic              disp_next,
  output logic [DATA_W-1:0] disp_out,
  output logic              disp_valid,
  output logic [PW-1:0]     pending,
  output logic              overflow,
  output logic              halt,
  output logic [CNT_W-1:0]  print_cnt
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic ev, prt, ext, empty, full, pop, direct, push, drop;
  always_comb begin
    ev     = syscall & ~stall & ~halt;
    prt    = ev & (rf_a != EXIT_CODE);
    ext    = ev & (rf_a == EXIT_CODE);
    empty  = pending == '0;
    full   = pending == PW'(DEPTH);
    pop    = disp_next & ~empty;
    // With an empty FIFO the print goes straight to the display on the first
    // capture, or bypasses the queue when the operator is advancing anyway.
    direct = prt & empty & (~disp_valid | disp_next);
    push   = prt & ~direct & (~full | pop);
    drop   = prt & full & ~pop;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_out   <= '0;
      disp_valid <= 1'b0;
      pending    <= '0;
      overflow   <= 1'b0;
      halt       <= 1'b0;
      print_cnt  <= '0;
      rd         <= '0;
      wr         <= '0;
    end else begin
      if (pop) disp_out <= mem[rd];
      else if (direct) disp_out <= rf_b;
      if (direct) disp_valid <= 1'b1;
      if (pop) rd <= rd + AW'(1);
      if (push) wr <= wr + AW'(1);
      pending <= pending + PW'(push) - PW'(pop);
      if (drop) overflow <= 1'b1;
      if (ext) halt <= 1'b1;
      if (prt && print_cnt != '1) print_cnt <= print_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[wr] <= rf_b;
endmodule

// File: tb/tb_syscall_disp_queue.sv
// tb_syscall_disp_queue: directed table vectors plus reset and saturation sequences.
module tb_syscall_disp_queue;
  logic clk = 0, rst = 0, syscall = 0, stall = 0, disp_next = 0;
  logic [31:0] rf_a = 0, rf_b = 0;
  logic [31:0] disp_out, out2;
  logic disp_valid, overflow, halt, v2, ov2, h2;
  logic [3:0] pending;
  logic [1:0] p2;
  logic [15:0] print_cnt;
  logic [2:0] c2;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  syscall_disp_queue dut (
    .clk(clk), .rst(rst), .syscall(syscall), .stall(stall), .rf_a(rf_a), .rf_b(rf_b),
    .disp_next(disp_next), .disp_out(disp_out), .disp_valid(disp_valid), .pending(pending),
    .overflow(overflow), .halt(halt), .print_cnt(print_cnt)
  );

  syscall_disp_queue #(.DEPTH(2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .syscall(syscall), .stall(stall), .rf_a(rf_a), .rf_b(rf_b),
    .disp_next(disp_next), .disp_out(out2), .disp_valid(v2), .pending(p2),
    .overflow(ov2), .halt(h2), .print_cnt(c2)
  );

  typedef struct {
    logic sc, st, nx;
    logic [31:0] a, b, out;
    logic v;
    logic [3:0] p;
    logic ov, h;
    logic [15:0] c;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(logic sc, st, nx, logic [31:0] a, b, out, logic v,
                              logic [3:0] p, logic ov, h, logic [15:0] c);
    vec_t t;
    t.sc = sc; t.st = st; t.nx = nx; t.a = a; t.b = b; t.out = out;
    t.v = v; t.p = p; t.ov = ov; t.h = h; t.c = c;
    return t;
  endfunction

  function automatic logic [63:0] snap();
    return {9'd0, disp_out, disp_valid, pending, overflow, halt, print_cnt};
  endfunction

  task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  task automatic drive(logic sc, st, nx, logic [31:0] a, b);
    @(negedge clk);
    syscall = sc; stall = st; disp_next = nx; rf_a = a; rf_b = b;
  endtask

  initial begin
    // print 5, queue 6..8, drain, bypass
    tv.push_back(mk(1,0,0, 1, 5,     5, 1, 0, 0, 0, 1));
    tv.push_back(mk(1,0,0, 1, 6,     5, 1, 1, 0, 0, 2));
    tv.push_back(mk(1,0,0, 1, 7,     5, 1, 2, 0, 0, 3));
    tv.push_back(mk(1,0,0, 1, 8,     5, 1, 3, 0, 0, 4));
    tv.push_back(mk(0,0,1, 0, 0,     6, 1, 2, 0, 0, 4));
    tv.push_back(mk(0,0,1, 0, 0,     7, 1, 1, 0, 0, 4));
    tv.push_back(mk(0,0,1, 0, 0,     8, 1, 0, 0, 0, 4));
    tv.push_back(mk(0,0,1, 0, 0,     8, 1, 0, 0, 0, 4));
    tv.push_back(mk(1,0,1, 1, 'hAA, 'hAA, 1, 0, 0, 0, 5));
    // fill with 2..9, overflow on 10, full pop+push of 11
    for (int i = 2; i <= 9; i++)
      tv.push_back(mk(1,0,0, 1, i, 'hAA, 1, 4'(i-1), 0, 0, 16'(i+4)));
    tv.push_back(mk(1,0,0, 1, 10,    'hAA, 1, 8, 1, 0, 14));
    tv.push_back(mk(1,0,1, 1, 11,    2, 1, 8, 1, 0, 15));
    for (int i = 3; i <= 9; i++)
      tv.push_back(mk(0,0,1, 0, 0,   i, 1, 4'(10-i), 1, 0, 15));
    tv.push_back(mk(0,0,1, 0, 0,     11, 1, 0, 1, 0, 15));
    // stalled syscall yields one event, then exit and ignored print
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(1,1,0, 1, 'h42, 11, 1, 0, 1, 0, 15));
    tv.push_back(mk(1,0,0, 1, 'h42,  11, 1, 1, 1, 0, 16));
    tv.push_back(mk(0,0,0, 0, 0,     11, 1, 1, 1, 0, 16));
    tv.push_back(mk(1,0,0, 'ha, 0,   11, 1, 1, 1, 1, 16));
    tv.push_back(mk(1,0,0, 1, 'h99,  11, 1, 1, 1, 1, 16));
    tv.push_back(mk(0,0,1, 0, 0,     'h42, 1, 0, 1, 1, 16));
    tv.push_back(mk(1,1,0, 'ha, 0,   'h42, 1, 0, 1, 1, 16));

    repeat (2) @(negedge clk);
    chk("reset_state", snap(), 64'd0);
    rst = 1;
    foreach (tv[i]) begin
      drive(tv[i].sc, tv[i].st, tv[i].nx, tv[i].a, tv[i].b);
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), snap(),
          {9'd0, tv[i].out, tv[i].v, tv[i].p, tv[i].ov, tv[i].h, tv[i].c});
    end

    // asynchronous reset with queued data and halt set
    drive(0,0,0, 0, 0); rst = 0;
    @(negedge clk); rst = 1;
    for (int i = 1; i <= 5; i++) drive(1,0,0, 1, i);
    drive(1,0,0, 'ha, 0);
    drive(0,0,0, 0, 0);
    #1 chk("pre_async", snap(), {9'd0, 32'd1, 1'b1, 4'd4, 1'b0, 1'b1, 16'd5});
    @(posedge clk); #2 rst = 0;
    #1 chk("async_reset", snap(), 64'd0);
    chk("async_reset2", {out2, v2, p2, ov2, h2, c2}, '0);

    // small instance: overflow at DEPTH=2 and counter saturation
    @(negedge clk); rst = 1;
    for (int i = 1; i <= 9; i++) drive(1,0,0, 1, i);
    drive(0,0,0, 0, 0);
    #1 chk("sat_small", {32'd0, out2, v2, p2, ov2, h2, c2}, {32'd0, 32'd1, 1'b1, 2'd2, 1'b1, 1'b0, 3'd7});
    chk("sat_big", snap(), {9'd0, 32'd1, 1'b1, 4'd8, 1'b0, 1'b0, 16'd9});
    drive(0,0,1, 0, 0);
    @(posedge clk); #1;
    chk("small_pop", {32'd0, out2, v2, p2, ov2, h2, c2}, {32'd0, 32'd2, 1'b1, 2'd1, 1'b1, 1'b0, 3'd7});
    disp_next = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/syscall_disp_queue.md
# syscall_disp_queue

Parametrised syscall print/halt capture block for the pipelined CPU, sitting beside the write-back stage and feeding the seven-segment display driver. It decodes the syscall service code and argument on each non-stalled syscall. Print values are queued in a DEPTH-entry FIFO so the operator can step through them with a button instead of losing all but the newest. The exit service raises a sticky halt flag.

## Interface
- DATA_W, 32: width of the syscall argument and displayed value.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- EXIT_CODE, 32'h0000000a: service code (compared on full DATA_W) meaning "halt".
- CNT_W, 16: width of the print counter.

- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; asserting (low) clears all state immediately.
- syscall  in  1  syscall instruction present in write-back this cycle.
- stall  in  1  write-back held; syscall ignored while high.
- rf_a  in  DATA_W  service code register value.
- rf_b  in  DATA_W  argument register value.
- disp_next  in  1  single-cycle pulse (already debounced and edge-detected upstream): advance display to next queued value.
- disp_out  out  DATA_W  value currently displayed.
- disp_valid  out  1  disp_out holds a captured value.
- pending  out  $clog2(DEPTH)+1  entries waiting in FIFO (0..DEPTH).
- overflow  out  1  sticky: a print was dropped because the FIFO was full.
- halt  out  1  sticky: exit syscall accepted.
- print_cnt  out  CNT_W  print events accepted since reset, saturating at all-ones.

## Operation
- Event qualification: ev = syscall & ~stall & ~halt. Print event: ev & (rf_a != EXIT_CODE). Exit event: ev & (rf_a == EXIT_CODE).
- Exit event: halt <= 1; no other state changes. Once halt is set, all later syscalls are ignored. disp_next still drains the FIFO.
- Display register cur/disp_valid:
  - First print after reset (disp_valid==0, FIFO empty) loads cur directly and sets disp_valid.
  - Otherwise a print pushes rf_b to the FIFO tail.
- Pop: disp_next with pending>0 loads cur <= head and removes the head.
- disp_next with pending==0 is a no-op.
- Simultaneous print and pop:
  - pending==0, disp_valid==1: bypass; cur <= rf_b and the FIFO is unchanged.
  - 0<pending<DEPTH: pop the head into cur and push rf_b; pending is unchanged.
  - pending==DEPTH: pop and push both happen; there is no overflow.
- Full FIFO with a print and no pop: rf_b is dropped and overflow <= 1 (sticky). print_cnt still increments.
- print_cnt increments on every print event, including dropped ones. It holds at 2^CNT_W-1.
- FIFO: circular buffer, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. pending is a separate counter. The full/empty decision uses pending.
- Reset values: disp_out=0, disp_valid=0, pending=0, overflow=0, halt=0, print_cnt=0, both pointers 0. FIFO storage is not required to be cleared.

## Timing
- All outputs are registered. An event sampled on rising edge N is visible after edge N; there is no combinational input-to-output path.
- Reset takes effect asynchronously mid-operation and discards queued data. Deassertion is synchronised upstream; the first event is accepted on the first edge with rst high.
- Throughput: one print and one pop per cycle. A stall lasting any number of cycles produces exactly one event, on the first cycle stall is low.
- Latency from disp_next to the new disp_out: 1 cycle.

## Test plan
- Reset, then print 5 (rf_a=1, rf_b=5, one cycle) -> next cycle disp_out=5, disp_valid=1, pending=0, print_cnt=1.
- With disp_out=5, print 6,7,8 back-to-back -> pending=3 and disp_out stays 5. Then three disp_next pulses -> disp_out 6, 7, 8 on successive cycles and pending reaches 0. A fourth pulse leaves disp_out=8.
- DEPTH=8: after the first value, push 8 more values, then a 10th print with no pop -> pending=8, overflow=1, print_cnt=10. Draining yields values 2..9 and the 10th is lost. Also check a print and pop in the same cycle while full -> pending stays 8 with no overflow.
- Simultaneous print 0xAA and disp_next with pending=0, disp_valid=1 -> disp_out=0xAA next cycle, pending=0.
- syscall high with stall high for 3 cycles, then stall low (rf_b=0x42) -> exactly one push and print_cnt +1. Then exit (rf_a=0xa) -> halt=1. A following print 0x99 -> ignored and print_cnt unchanged.
- Pull rst low mid-cycle with pending=4, halt=1 -> all outputs zero immediately without a clock edge.
